// File: rtl/imm_extend_pipe.sv
// Immediate-extension stage: widens an IN_W-bit immediate in one of four modes and
// registers the result behind a valid/ready handshake with a 2-entry skid buffer.
module imm_extend_pipe #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IN_W-1:0]  data_i,
    input  logic [1:0]       mode_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] data_o,
    output logic [1:0]       mode_o
);

    localparam int unsigned PadW = OUT_W - IN_W;

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext;

    logic             m_valid_q, m_valid_d;
    logic [OUT_W-1:0] m_data_q, m_data_d;
    logic [1:0]       m_mode_q, m_mode_d;
    logic             s_valid_q, s_valid_d;
    logic [OUT_W-1:0] s_data_q, s_data_d;
    logic [1:0]       s_mode_q, s_mode_d;

    logic accept;
    logic m_free;

    assign sext = {{PadW{data_i[IN_W-1]}}, data_i};

    always_comb begin
        ext = sext;
        unique case (mode_i)
            2'b00: ext = sext;
            2'b01: ext = {{PadW{1'b0}}, data_i};
            2'b10: ext = {data_i, {PadW{1'b0}}};
            2'b11: ext = {sext[OUT_W-3:0], 2'b00};
            default: ext = sext;
        endcase
    end

    // in_ready depends only on registered state, so no path from out_ready_i.
    assign in_ready_o = ~s_valid_q;
    assign accept     = in_valid_i & in_ready_o;
    assign m_free     = ~m_valid_q | out_ready_i;

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_mode_d  = m_mode_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        s_mode_d  = s_mode_q;
        if (flush_i) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (m_free && s_valid_q) begin
            m_valid_d = 1'b1;
            m_data_d  = s_data_q;
            m_mode_d  = s_mode_q;
            s_valid_d = 1'b0;
        end else if (m_free && accept) begin
            m_valid_d = 1'b1;
            m_data_d  = ext;
            m_mode_d  = mode_i;
        end else if (m_free) begin
            m_valid_d = 1'b0;
        end else if (accept) begin
            s_valid_d = 1'b1;
            s_data_d  = ext;
            s_mode_d  = mode_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_mode_q  <= 2'b00;
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
            s_mode_q  <= 2'b00;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_mode_q  <= m_mode_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
            s_mode_q  <= s_mode_d;
        end
    end

    assign out_valid_o = m_valid_q;
    assign data_o      = m_data_q;
    assign mode_o      = m_mode_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe: modes, streaming, backpressure,
// flush, asynchronous reset and a narrow-parameter instance.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] data_i;
    logic [1:0]  mode_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] data_o;
    logic [1:0]  mode_o;

    logic        in_valid_n;
    logic        in_ready_n;
    logic [11:0] data_n;
    logic [1:0]  mode_n;
    logic        out_valid_n;
    logic [15:0] data_on;
    logic [1:0]  mode_on;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) u_dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .data_i      (data_i),
        .mode_i      (mode_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .data_o      (data_o),
        .mode_o      (mode_o)
    );

    imm_extend_pipe #(.IN_W(12), .OUT_W(16)) u_dut_narrow (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (1'b0),
        .in_valid_i  (in_valid_n),
        .in_ready_o  (in_ready_n),
        .data_i      (data_n),
        .mode_i      (mode_n),
        .out_valid_o (out_valid_n),
        .out_ready_i (1'b1),
        .data_o      (data_on),
        .mode_o      (mode_on)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mode vectors with hand-computed expected results.
    logic [15:0] mv_data [8] = '{16'h8004, 16'h8004, 16'h8004, 16'h8004,
                                 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    logic [1:0]  mv_mode [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
    logic [31:0] mv_exp  [8] = '{32'hFFFF8004, 32'h00008004, 32'h80040000, 32'hFFFE0010,
                                 32'h00007FFF, 32'h00007FFF, 32'h7FFF0000, 32'h0001FFFC};
    // Streaming values in sign mode.
    logic [15:0] sv_data [8] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                                 16'h8888, 16'h9999, 16'hAAAA, 16'hFFFF};
    logic [31:0] sv_exp  [8] = '{32'h00001111, 32'h00002222, 32'h00003333, 32'h00004444,
                                 32'hFFFF8888, 32'hFFFF9999, 32'hFFFFAAAA, 32'hFFFFFFFF};

    initial begin
        rst_i       = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        data_i      = '0;
        mode_i      = 2'b00;
        out_ready_i = 1'b1;
        in_valid_n  = 1'b0;
        data_n      = '0;
        mode_n      = 2'b00;
        #3;
        check("rst_out_valid", {31'b0, out_valid_o}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready_o}, 32'd1);
        check("rst_data", data_o, 32'd0);
        check("rst_mode", {30'b0, mode_o}, 32'd0);
        tick();
        tick();
        @(negedge clk);
        rst_i = 1'b1;
        tick();
        check("idle_out_valid", {31'b0, out_valid_o}, 32'd0);

        // Mode checks, one accept each with 1-cycle latency.
        for (int i = 0; i < 8; i++) begin
            in_valid_i = 1'b1;
            data_i     = mv_data[i];
            mode_i     = mv_mode[i];
            tick();
            check($sformatf("mode%0d_valid", i), {31'b0, out_valid_o}, 32'd1);
            check($sformatf("mode%0d_data", i), data_o, mv_exp[i]);
            check($sformatf("mode%0d_mode", i), {30'b0, mode_o}, {30'b0, mv_mode[i]});
            in_valid_i = 1'b0;
            tick();
            check($sformatf("mode%0d_drain", i), {31'b0, out_valid_o}, 32'd0);
        end

        // Back-to-back streaming, no bubbles.
        for (int i = 0; i < 8; i++) begin
            in_valid_i = 1'b1;
            data_i     = sv_data[i];
            mode_i     = 2'b00;
            check($sformatf("stream%0d_ready", i), {31'b0, in_ready_o}, 32'd1);
            tick();
            check($sformatf("stream%0d_valid", i), {31'b0, out_valid_o}, 32'd1);
            check($sformatf("stream%0d_data", i), data_o, sv_exp[i]);
        end
        in_valid_i = 1'b0;
        tick();
        check("stream_end", {31'b0, out_valid_o}, 32'd0);

        // Backpressure: two accepts then stall.
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        mode_i      = 2'b01;
        data_i      = 16'h00A1;
        tick();
        check("bp_ready1", {31'b0, in_ready_o}, 32'd1);
        data_i = 16'h00B2;
        tick();
        check("bp_ready2", {31'b0, in_ready_o}, 32'd0);
        check("bp_hold_a", data_o, 32'h000000A1);
        data_i = 16'h00C3;
        tick();
        tick();
        check("bp_stall_ready", {31'b0, in_ready_o}, 32'd0);
        check("bp_stall_a", data_o, 32'h000000A1);
        check("bp_stall_valid", {31'b0, out_valid_o}, 32'd1);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        tick();
        check("bp_b_valid", {31'b0, out_valid_o}, 32'd1);
        check("bp_b_data", data_o, 32'h000000B2);
        check("bp_restart_ready", {31'b0, in_ready_o}, 32'd1);
        tick();
        check("bp_empty", {31'b0, out_valid_o}, 32'd0);

        // Flush with M and S full and an offered input.
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        mode_i      = 2'b10;
        data_i      = 16'h0D0D;
        tick();
        data_i = 16'h0E0E;
        tick();
        check("fl_full", {31'b0, in_ready_o}, 32'd0);
        data_i  = 16'h0F0F;
        flush_i = 1'b1;
        tick();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        check("fl_valid", {31'b0, out_valid_o}, 32'd0);
        check("fl_ready", {31'b0, in_ready_o}, 32'd1);
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("fl_quiet%0d", i), {31'b0, out_valid_o}, 32'd0);
        end
        // Flush coinciding with an accept on an empty unit.
        in_valid_i = 1'b1;
        data_i     = 16'h1234;
        flush_i    = 1'b1;
        tick();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        check("fl_accept_drop", {31'b0, out_valid_o}, 32'd0);

        // Asynchronous reset with M and S full.
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        mode_i      = 2'b00;
        data_i      = 16'h8001;
        tick();
        data_i = 16'h8002;
        tick();
        in_valid_i = 1'b0;
        check("ar_full_ready", {31'b0, in_ready_o}, 32'd0);
        #2;
        rst_i = 1'b0;
        #1;
        check("ar_valid", {31'b0, out_valid_o}, 32'd0);
        check("ar_ready", {31'b0, in_ready_o}, 32'd1);
        check("ar_data", data_o, 32'd0);
        @(negedge clk);
        rst_i       = 1'b1;
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        data_i      = 16'h8004;
        mode_i      = 2'b11;
        tick();
        in_valid_i = 1'b0;
        check("ar_first_valid", {31'b0, out_valid_o}, 32'd1);
        check("ar_first_data", data_o, 32'hFFFE0010);

        // Narrow parameterisation.
        in_valid_n = 1'b1;
        data_n     = 12'h800;
        mode_n     = 2'b00;
        tick();
        check("nar_sign_valid", {31'b0, out_valid_n}, 32'd1);
        check("nar_sign", {16'b0, data_on}, 32'h0000F800);
        mode_n = 2'b11;
        tick();
        in_valid_n = 1'b0;
        check("nar_branch", {16'b0, data_on}, 32'h0000E000);
        check("nar_branch_mode", {30'b0, mode_on}, 32'd3);
        check("nar_ready", {31'b0, in_ready_n}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
